// File: rtl/lcd_cmd_scheduler_if.sv
// Byte request channel between the message logic and the LCD command scheduler.
// The master offers a byte with req_valid; the scheduler takes it when req_ready is high.
interface lcd_cmd_scheduler_if;
  logic       req_valid;
  logic       req_ready;
  logic       req_rs;
  logic [7:0] req_data;

  modport master (output req_valid, output req_rs, output req_data, input req_ready);
  modport slave  (input req_valid, input req_rs, input req_data, output req_ready);
endinterface

// File: rtl/lcd_cmd_scheduler.sv
// 4-bit character-LCD write sequencer: power-on init, then each accepted byte
// is sent as two timed lcd_en strobes (high nibble, then low nibble).
module lcd_cmd_scheduler #(
  parameter int T_POWERUP = 750000,
  parameter int T_INIT1   = 205000,
  parameter int T_INIT2   = 5000,
  parameter int T_SETUP   = 2,
  parameter int T_EN      = 12,
  parameter int T_NIB_GAP = 50,
  parameter int T_CMD     = 2000,
  parameter int T_CLEAR   = 82000
) (
  input  logic                 clk,
  input  logic                 reset,
  lcd_cmd_scheduler_if.slave   req_if,
  output logic                 o_init_done,
  output logic                 o_busy,
  output logic [3:0]           o_lcd_d,
  output logic                 o_lcd_rs,
  output logic                 o_lcd_en,
  output logic                 o_lcd_rw
);

  // Timer holds "cycles remaining minus one" so a state lasting N cycles loads N-1.
  localparam logic [19:0] L_POWERUP = 20'(T_POWERUP - 1);
  localparam logic [19:0] L_INIT1   = 20'(T_INIT1 - 1);
  localparam logic [19:0] L_INIT2   = 20'(T_INIT2 - 1);
  localparam logic [19:0] L_SETUP   = 20'(T_SETUP - 1);
  localparam logic [19:0] L_EN      = 20'(T_EN - 1);
  localparam logic [19:0] L_NIB_GAP = 20'(T_NIB_GAP - 1);
  localparam logic [19:0] L_CMD     = 20'(T_CMD - 1);
  localparam logic [19:0] L_CLEAR   = 20'(T_CLEAR - 1);

  // INIT_NIB and CFG double as phase tags held in r_phase while the shared
  // SETUP/PULSE/HOLD/WAIT states do the actual pin work.
  typedef enum logic [3:0] {
    PWR_WAIT, INIT_NIB, INIT_WAIT, CFG, IDLE, SETUP, PULSE, HOLD, GAP, WAIT
  } state_t;

  function automatic logic [3:0] f_init_nib(input logic [1:0] step);
    return (step == 2'd3) ? 4'h2 : 4'h3;
  endfunction

  function automatic logic [19:0] f_init_wait(input logic [1:0] step);
    case (step)
      2'd0:    return L_INIT1;
      2'd1:    return L_INIT2;
      default: return L_CMD;
    endcase
  endfunction

  function automatic logic [7:0] f_cfg_byte(input logic [1:0] step);
    case (step)
      2'd0:    return 8'h28;
      2'd1:    return 8'h06;
      2'd2:    return 8'h0C;
      default: return 8'h01;
    endcase
  endfunction

  state_t      r_state, w_state_next;
  state_t      r_phase, w_phase_next;
  logic [1:0]  r_step, w_step_next;
  logic [19:0] r_timer, w_timer_next;
  logic        r_low, w_low_next;
  logic [7:0]  r_byte, w_byte_next;
  logic        r_rs, w_rs_next;
  logic [3:0]  r_lcd_d, w_lcd_d_next;
  logic        r_lcd_rs, w_lcd_rs_next;
  logic        r_lcd_en, w_lcd_en_next;
  logic        r_ready, w_ready_next;
  logic        r_init_done, w_init_done_next;
  logic        r_busy;

  logic        w_timer_zero;
  logic        w_is_clear;
  logic        w_launch_nib;
  logic [1:0]  w_nib_step;
  logic        w_launch_byte;
  logic [7:0]  w_launch_data;
  logic        w_launch_rs;

  assign w_timer_zero = (r_timer == 20'd0);
  assign w_is_clear   = !r_rs && ((r_byte == 8'h01) || (r_byte == 8'h02));

  always_comb begin
    w_state_next     = r_state;
    w_phase_next     = r_phase;
    w_step_next      = r_step;
    w_timer_next     = r_timer;
    w_low_next       = r_low;
    w_byte_next      = r_byte;
    w_rs_next        = r_rs;
    w_lcd_d_next     = r_lcd_d;
    w_lcd_rs_next    = r_lcd_rs;
    w_lcd_en_next    = r_lcd_en;
    w_ready_next     = r_ready;
    w_init_done_next = r_init_done;
    w_launch_nib     = 1'b0;
    w_nib_step       = r_step;
    w_launch_byte    = 1'b0;
    w_launch_data    = 8'h00;
    w_launch_rs      = 1'b0;

    case (r_state)
      PWR_WAIT: begin
        if (w_timer_zero) w_launch_nib = 1'b1;
        else              w_timer_next = r_timer - 20'd1;
      end
      SETUP: begin
        if (w_timer_zero) begin
          w_state_next  = PULSE;
          w_lcd_en_next = 1'b1;
          w_timer_next  = L_EN;
        end else w_timer_next = r_timer - 20'd1;
      end
      PULSE: begin
        if (w_timer_zero) begin
          w_state_next  = HOLD;
          w_lcd_en_next = 1'b0;
        end else w_timer_next = r_timer - 20'd1;
      end
      HOLD: begin
        if (r_phase == INIT_NIB) begin
          w_state_next = INIT_WAIT;
          w_timer_next = f_init_wait(r_step);
        end else if (!r_low) begin
          w_state_next = GAP;
          w_timer_next = L_NIB_GAP;
        end else begin
          w_state_next = WAIT;
          w_timer_next = w_is_clear ? L_CLEAR : L_CMD;
        end
      end
      GAP: begin
        if (w_timer_zero) begin
          w_state_next = SETUP;
          w_lcd_d_next = r_byte[3:0];
          w_low_next   = 1'b1;
          w_timer_next = L_SETUP;
        end else w_timer_next = r_timer - 20'd1;
      end
      INIT_WAIT: begin
        if (w_timer_zero) begin
          if (r_step == 2'd3) begin
            w_phase_next  = CFG;
            w_step_next   = 2'd0;
            w_launch_byte = 1'b1;
            w_launch_data = f_cfg_byte(2'd0);
          end else begin
            w_step_next  = r_step + 2'd1;
            w_launch_nib = 1'b1;
            w_nib_step   = r_step + 2'd1;
          end
        end else w_timer_next = r_timer - 20'd1;
      end
      WAIT: begin
        if (w_timer_zero) begin
          if (r_phase == CFG && r_step != 2'd3) begin
            w_step_next   = r_step + 2'd1;
            w_launch_byte = 1'b1;
            w_launch_data = f_cfg_byte(r_step + 2'd1);
          end else begin
            w_state_next     = IDLE;
            w_phase_next     = IDLE;
            w_step_next      = 2'd0;
            w_ready_next     = 1'b1;
            w_init_done_next = 1'b1;
          end
        end else w_timer_next = r_timer - 20'd1;
      end
      IDLE: begin
        if (req_if.req_valid && r_ready) begin
          w_launch_byte = 1'b1;
          w_launch_data = req_if.req_data;
          w_launch_rs   = req_if.req_rs;
          w_ready_next  = 1'b0;
        end
      end
      default: w_state_next = PWR_WAIT;
    endcase

    if (w_launch_nib) begin
      w_state_next  = SETUP;
      w_lcd_d_next  = f_init_nib(w_nib_step);
      w_lcd_rs_next = 1'b0;
      w_timer_next  = L_SETUP;
    end
    if (w_launch_byte) begin
      w_state_next  = SETUP;
      w_byte_next   = w_launch_data;
      w_rs_next     = w_launch_rs;
      w_lcd_d_next  = w_launch_data[7:4];
      w_lcd_rs_next = w_launch_rs;
      w_low_next    = 1'b0;
      w_timer_next  = L_SETUP;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= PWR_WAIT;
      r_phase     <= INIT_NIB;
      r_step      <= 2'd0;
      r_timer     <= L_POWERUP;
      r_low       <= 1'b0;
      r_byte      <= 8'h00;
      r_rs        <= 1'b0;
      r_lcd_d     <= 4'h0;
      r_lcd_rs    <= 1'b0;
      r_lcd_en    <= 1'b0;
      r_ready     <= 1'b0;
      r_init_done <= 1'b0;
      r_busy      <= 1'b1;
    end else begin
      r_state     <= w_state_next;
      r_phase     <= w_phase_next;
      r_step      <= w_step_next;
      r_timer     <= w_timer_next;
      r_low       <= w_low_next;
      r_byte      <= w_byte_next;
      r_rs        <= w_rs_next;
      r_lcd_d     <= w_lcd_d_next;
      r_lcd_rs    <= w_lcd_rs_next;
      r_lcd_en    <= w_lcd_en_next;
      r_ready     <= w_ready_next;
      r_init_done <= w_init_done_next;
      r_busy      <= ~w_ready_next;
    end
  end

  assign req_if.req_ready = r_ready;
  assign o_init_done      = r_init_done;
  assign o_busy           = r_busy;
  assign o_lcd_d          = r_lcd_d;
  assign o_lcd_rs         = r_lcd_rs;
  assign o_lcd_en         = r_lcd_en;
  assign o_lcd_rw         = 1'b0;

endmodule

// File: tb/tb_lcd_cmd_scheduler.sv
// Directed bench for lcd_cmd_scheduler with shortened init timings; a monitor
// logs strobes/handshakes by cycle number and the checks compare against the timing rules.
module tb_lcd_cmd_scheduler;
  localparam int P_POWERUP = 100;
  localparam int P_INIT1   = 50;
  localparam int P_INIT2   = 20;
  localparam int P_CMD     = 30;
  localparam int P_CLEAR   = 300;
  localparam int P_SETUP   = 2;
  localparam int P_EN      = 12;
  localparam int P_GAP     = 50;
  localparam int BYTE_LEN  = 2 * (P_SETUP + P_EN + 1) + P_GAP;
  localparam int INIT_LEN  = P_POWERUP + 4 * (P_SETUP + P_EN + 1) + P_INIT1 + P_INIT2
                           + 2 * P_CMD + 3 * (BYTE_LEN + P_CMD) + (BYTE_LEN + P_CLEAR);

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  lcd_cmd_scheduler_if bus ();
  logic       init_done, busy, lcd_rs, lcd_en, lcd_rw;
  logic [3:0] lcd_d;

  lcd_cmd_scheduler #(
    .T_POWERUP(P_POWERUP), .T_INIT1(P_INIT1), .T_INIT2(P_INIT2), .T_SETUP(P_SETUP),
    .T_EN(P_EN), .T_NIB_GAP(P_GAP), .T_CMD(P_CMD), .T_CLEAR(P_CLEAR)
  ) dut (
    .clk(clk), .reset(reset), .req_if(bus),
    .o_init_done(init_done), .o_busy(busy), .o_lcd_d(lcd_d),
    .o_lcd_rs(lcd_rs), .o_lcd_en(lcd_en), .o_lcd_rw(lcd_rw)
  );

  int         cyc = 0;
  int         last_rst = 0;
  int         acc_cyc[$];
  logic [8:0] acc_val[$];
  int         rise_cyc[$];
  logic [4:0] rise_val[$];
  int         fall_cyc[$];
  int         rdy_rise = -1;
  int         done_rise = -1;
  logic       prev_en = 1'b0, prev_rdy = 1'b0, prev_done = 1'b0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (reset) last_rst <= cyc + 1;
    if (bus.req_valid && bus.req_ready) begin
      acc_cyc.push_back(cyc + 1);
      acc_val.push_back({bus.req_rs, bus.req_data});
    end
  end

  always @(negedge clk) begin
    if (lcd_en && !prev_en) begin
      rise_cyc.push_back(cyc);
      rise_val.push_back({lcd_rs, lcd_d});
    end
    if (!lcd_en && prev_en) fall_cyc.push_back(cyc);
    if (bus.req_ready && !prev_rdy) rdy_rise <= cyc;
    if (init_done && !prev_done) done_rise <= cyc;
    prev_en   <= lcd_en;
    prev_rdy  <= bus.req_ready;
    prev_done <= init_done;
  end

  int n_checks = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_ready(input string name, input int budget);
    int i = 0;
    while (!bus.req_ready && i < budget) begin tick(); i++; end
    chk({name, "_ready_timeout"}, 32'(bus.req_ready), 1);
  endtask

  task automatic wait_done(input string name, input int budget);
    int i = 0;
    while (!init_done && i < budget) begin tick(); i++; end
    chk({name, "_init_timeout"}, 32'(init_done), 1);
  endtask

  task automatic wait_accept(input string name, input int n_before, input int budget);
    int i = 0;
    while (acc_cyc.size() <= n_before && i < budget) begin tick(); i++; end
    chk({name, "_accept_timeout"}, 32'(acc_cyc.size() > n_before), 1);
  endtask

  task automatic check_init(input string name, input int base, input int r);
    logic [3:0] exp_nib [12];
    exp_nib = '{4'h3, 4'h3, 4'h3, 4'h2, 4'h2, 4'h8, 4'h0, 4'h6, 4'h0, 4'hC, 4'h0, 4'h1};
    chk({name, "_strobe_count"}, rise_cyc.size() - base, 12);
    for (int k = 0; k < 12; k++)
      if (base + k < rise_val.size())
        chk($sformatf("%s_nib%0d", name, k), rise_val[base + k], {1'b0, exp_nib[k]});
    if (base < rise_cyc.size())
      chk({name, "_first_rise"}, rise_cyc[base], r + P_POWERUP + P_SETUP);
    chk({name, "_done_cycle"}, done_rise, r + INIT_LEN);
  endtask

  task automatic check_byte(input string name, input int p, input int e0,
                            input logic rs, input logic [3:0] hi, input logic [3:0] lo,
                            input int wait_len);
    chk({name, "_strobes"}, rise_cyc.size() - p, 2);
    if (p + 1 < rise_cyc.size() && p + 1 < fall_cyc.size()) begin
      chk({name, "_hi_rise"}, rise_cyc[p], e0 + 2);
      chk({name, "_hi_val"},  rise_val[p], {rs, hi});
      chk({name, "_hi_fall"}, fall_cyc[p], e0 + 14);
      chk({name, "_lo_rise"}, rise_cyc[p + 1], e0 + 67);
      chk({name, "_lo_val"},  rise_val[p + 1], {rs, lo});
      chk({name, "_lo_fall"}, fall_cyc[p + 1], e0 + 79);
    end
    chk({name, "_ready_back"}, rdy_rise, e0 + BYTE_LEN + wait_len);
  endtask

  typedef struct {
    logic       rs;
    logic [7:0] data;
    logic [3:0] hi;
    logic [3:0] lo;
    int         wait_len;
  } vec_t;

  initial begin
    vec_t       tbl [6];
    logic [7:0] b2b [3];
    int         p, a, e0, r;

    tbl[0] = '{1'b1, 8'h41, 4'h4, 4'h1, P_CMD};
    tbl[1] = '{1'b0, 8'h01, 4'h0, 4'h1, P_CLEAR};
    tbl[2] = '{1'b1, 8'h01, 4'h0, 4'h1, P_CMD};
    tbl[3] = '{1'b0, 8'h02, 4'h0, 4'h2, P_CLEAR};
    tbl[4] = '{1'b0, 8'h28, 4'h2, 4'h8, P_CMD};
    tbl[5] = '{1'b1, 8'hA5, 4'hA, 4'h5, P_CMD};
    b2b    = '{8'h48, 8'h69, 8'h21};

    bus.req_valid = 1'b0;
    bus.req_rs    = 1'b0;
    bus.req_data  = 8'h00;
    repeat (3) tick();

    chk("rst_lcd_en", 32'(lcd_en), 0);
    chk("rst_lcd_d", 32'(lcd_d), 0);
    chk("rst_lcd_rs", 32'(lcd_rs), 0);
    chk("rst_lcd_rw", 32'(lcd_rw), 0);
    chk("rst_ready", 32'(bus.req_ready), 0);
    chk("rst_init_done", 32'(init_done), 0);
    chk("rst_busy", 32'(busy), 1);

    reset = 1'b0;
    wait_done("init", 2 * INIT_LEN);
    r = last_rst;
    check_init("init", 0, r);
    chk("init_busy_low", 32'(busy), 0);
    repeat (20) tick();
    chk("init_quiet", rise_cyc.size(), 12);

    for (int i = 0; i < 6; i++) begin
      p = rise_cyc.size();
      a = acc_cyc.size();
      bus.req_valid = 1'b1;
      bus.req_rs    = tbl[i].rs;
      bus.req_data  = tbl[i].data;
      wait_accept($sformatf("vec%0d", i), a, 50);
      bus.req_valid = 1'b0;
      bus.req_rs    = ~tbl[i].rs;
      bus.req_data  = ~tbl[i].data;
      e0 = (acc_cyc.size() > a) ? acc_cyc[a] : 0;
      wait_ready($sformatf("vec%0d", i), 1000);
      check_byte($sformatf("vec%0d", i), p, e0, tbl[i].rs, tbl[i].hi, tbl[i].lo,
                 tbl[i].wait_len);
      $display("vec%0d rs=%0d data=%02h accepted at %0d", i, tbl[i].rs, tbl[i].data, e0);
    end

    p = rise_cyc.size();
    a = acc_cyc.size();
    bus.req_valid = 1'b1;
    bus.req_rs    = 1'b1;
    bus.req_data  = b2b[0];
    for (int k = 0; k < 3; k++) begin
      wait_accept($sformatf("b2b%0d", k), a + k, 1000);
      if (k < 2) bus.req_data = b2b[k + 1];
      else       bus.req_valid = 1'b0;
    end
    bus.req_data = 8'hFF;
    wait_ready("b2b", 1000);
    repeat (5) tick();
    chk("b2b_accept_count", acc_cyc.size() - a, 3);
    chk("b2b_strobe_count", rise_cyc.size() - p, 6);
    for (int k = 0; k < 3; k++) begin
      if (a + k < acc_val.size())
        chk($sformatf("b2b%0d_order", k), acc_val[a + k], {1'b1, b2b[k]});
      if (p + 2 * k + 1 < rise_val.size()) begin
        chk($sformatf("b2b%0d_hi", k), rise_val[p + 2 * k], {1'b1, b2b[k][7:4]});
        chk($sformatf("b2b%0d_lo", k), rise_val[p + 2 * k + 1], {1'b1, b2b[k][3:0]});
      end
      $display("b2b%0d data=%02h", k, b2b[k]);
    end

    p = rise_cyc.size();
    a = acc_cyc.size();
    bus.req_valid = 1'b1;
    bus.req_rs    = 1'b1;
    bus.req_data  = 8'h7E;
    wait_accept("mid_rst", a, 50);
    bus.req_valid = 1'b0;
    for (int i = 0; i < 200 && rise_cyc.size() < p + 2; i++) tick();
    tick();
    chk("mid_rst_en_high", 32'(lcd_en), 1);
    reset = 1'b1;
    tick();
    chk("mid_rst_en", 32'(lcd_en), 0);
    chk("mid_rst_ready", 32'(bus.req_ready), 0);
    chk("mid_rst_busy", 32'(busy), 1);
    chk("mid_rst_lcd_d", 32'(lcd_d), 0);
    chk("mid_rst_init_done", 32'(init_done), 0);
    reset = 1'b0;
    bus.req_valid = 1'b1;
    bus.req_rs    = 1'b1;
    bus.req_data  = 8'h55;
    a = acc_cyc.size();
    p = rise_cyc.size();
    wait_done("replay", 2 * INIT_LEN);
    r = last_rst;
    check_init("replay", p, r);
    chk("early_valid_no_accept", acc_cyc.size() - a, 0);
    wait_accept("early", a, 50);
    bus.req_valid = 1'b0;
    e0 = (acc_cyc.size() > a) ? acc_cyc[a] : 0;
    chk("early_accept_cycle", e0, r + INIT_LEN + 1);
    wait_ready("early", 1000);
    check_byte("early", p + 12, e0, 1'b1, 4'h5, 4'h5, P_CMD);
    $display("reset replay done, early byte accepted at %0d", e0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
